// File: rtl/stage3_mem_wb_if.sv
// rtl/stage3_mem_wb_if.sv - EX/ID-facing signal bundle of the memory/writeback stage
//
// Purpose: groups every non-clock/reset signal of stage3_mem_wb.
//   master : EX/ID side (drives EX->MEM bus and ID read info, receives results)
//   slave  : stage3_mem_wb
// Signals:
//   Ctl_MemtoReg_in/Ctl_RegWrite_in/Ctl_MemWrite_in, Rd_in, ALUresult_in,
//   MemWriteData_in, NOS_in      : EX->MEM pipeline inputs
//   Rs1_id/Rs2_id, RfData1_in/RfData2_in : ID register-read info
//   WriteData_out                : MEM result (forwarding source for EX)
//   EXE_forwarding_out           : forwarding select for the ID instruction
//   RegData1_out/RegData2_out    : ID operands (bypassed or raw)
//   Rf_we_out/Rf_waddr_out/Rf_wdata_out : register-file write port
interface stage3_mem_wb_if;
    logic        Ctl_MemtoReg_in;
    logic        Ctl_RegWrite_in;
    logic        Ctl_MemWrite_in;
    logic [4:0]  Rd_in;
    logic [31:0] ALUresult_in;
    logic [31:0] MemWriteData_in;
    logic        NOS_in;
    logic [4:0]  Rs1_id;
    logic [4:0]  Rs2_id;
    logic [31:0] RfData1_in;
    logic [31:0] RfData2_in;
    logic [31:0] WriteData_out;
    logic [1:0]  EXE_forwarding_out;
    logic [31:0] RegData1_out;
    logic [31:0] RegData2_out;
    logic        Rf_we_out;
    logic [4:0]  Rf_waddr_out;
    logic [31:0] Rf_wdata_out;

    modport master (
        output Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemWrite_in, Rd_in,
               ALUresult_in, MemWriteData_in, NOS_in, Rs1_id, Rs2_id,
               RfData1_in, RfData2_in,
        input  WriteData_out, EXE_forwarding_out, RegData1_out, RegData2_out,
               Rf_we_out, Rf_waddr_out, Rf_wdata_out
    );

    modport slave (
        input  Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemWrite_in, Rd_in,
               ALUresult_in, MemWriteData_in, NOS_in, Rs1_id, Rs2_id,
               RfData1_in, RfData2_in,
        output WriteData_out, EXE_forwarding_out, RegData1_out, RegData2_out,
               Rf_we_out, Rf_waddr_out, Rf_wdata_out
    );
endinterface

// File: rtl/stage3_mem_wb.sv
// rtl/stage3_mem_wb.sv - RISC-V memory/writeback stage with forwarding select and optional WB bypass
//
// Purpose: MEM pipeline register, word-wide data memory (combinational read,
// synchronous write), MEM result back to EX, EX forwarding select for the ID
// instruction, WB register driving the register-file write port.
// Optional feature: define STAGE3_WB_BYPASS_EN to bypass WB write data into the
// ID register operands; otherwise operands pass straight from the register file.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : stage3_mem_wb_if.slave (see interface file for signal list)
// Parameters:
//   ADDR_W : data-memory word-address width (2^ADDR_W words of 32 bits)
module stage3_mem_wb #(
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    stage3_mem_wb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    // MEM register
    logic        memtoreg_mem;
    logic        regwrite_mem;
    logic        memwrite_mem;
    logic [4:0]  rd_mem;
    logic [31:0] alu_mem;
    logic [31:0] store_data_mem;

    // WB register
    logic        regwrite_wb;
    logic [4:0]  rd_wb;
    logic [31:0] data_wb;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] mem_idx;
    logic              fwd_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            memtoreg_mem   <= 1'b0;
            regwrite_mem   <= 1'b0;
            memwrite_mem   <= 1'b0;
            rd_mem         <= 5'd0;
            alu_mem        <= 32'd0;
            store_data_mem <= 32'd0;
            regwrite_wb    <= 1'b0;
            rd_wb          <= 5'd0;
            data_wb        <= 32'd0;
        end else begin
            // A squashed EX instruction enters MEM as a bubble.
            memtoreg_mem   <= bus.Ctl_MemtoReg_in & ~bus.NOS_in;
            regwrite_mem   <= bus.Ctl_RegWrite_in & ~bus.NOS_in;
            memwrite_mem   <= bus.Ctl_MemWrite_in & ~bus.NOS_in;
            rd_mem         <= bus.Rd_in;
            alu_mem        <= bus.ALUresult_in;
            store_data_mem <= bus.MemWriteData_in;
            regwrite_wb    <= regwrite_mem;
            rd_wb          <= rd_mem;
            data_wb        <= bus.WriteData_out;
        end
    end

    // Byte offset is ignored and upper address bits wrap the word index.
    assign mem_idx = alu_mem[ADDR_W+1:2];

    // Memory contents are not reset; a store in MEM on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst && memwrite_mem) begin
            mem[mem_idx] <= store_data_mem;
        end
    end

    assign bus.WriteData_out = memtoreg_mem ? mem[mem_idx] : alu_mem;

    assign bus.Rf_we_out    = regwrite_wb & (rd_wb != 5'd0);
    assign bus.Rf_waddr_out = rd_wb;
    assign bus.Rf_wdata_out = data_wb;

    // Evaluated on the instruction still in EX; the ID/EX register latches it
    // so it applies when the consumer is in EX and the producer is in MEM.
    assign fwd_ok = bus.Ctl_RegWrite_in & ~bus.NOS_in & (bus.Rd_in != 5'd0);
    assign bus.EXE_forwarding_out[0] = fwd_ok & (bus.Rd_in == bus.Rs1_id);
    assign bus.EXE_forwarding_out[1] = fwd_ok & (bus.Rd_in == bus.Rs2_id);

`ifdef STAGE3_WB_BYPASS_EN
    // Distance-3 hazard: the producer is writing the register file this cycle.
    assign bus.RegData1_out = (bus.Rf_we_out && (bus.Rf_waddr_out == bus.Rs1_id))
                              ? bus.Rf_wdata_out : bus.RfData1_in;
    assign bus.RegData2_out = (bus.Rf_we_out && (bus.Rf_waddr_out == bus.Rs2_id))
                              ? bus.Rf_wdata_out : bus.RfData2_in;
`else
    // Register file must be write-first for the distance-3 case.
    assign bus.RegData1_out = bus.RfData1_in;
    assign bus.RegData2_out = bus.RfData2_in;
`endif
endmodule

// File: tb/tb_stage3_mem_wb.sv
// tb/tb_stage3_mem_wb.sv - directed self-checking bench for stage3_mem_wb
module tb_stage3_mem_wb;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    stage3_mem_wb_if bus ();

    stage3_mem_wb #(.ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        bus.Ctl_MemtoReg_in = 1'b0;
        bus.Ctl_RegWrite_in = 1'b0;
        bus.Ctl_MemWrite_in = 1'b0;
        bus.Rd_in           = 5'd0;
        bus.ALUresult_in    = 32'd0;
        bus.MemWriteData_in = 32'd0;
        bus.NOS_in          = 1'b0;
        bus.Rs1_id          = 5'd0;
        bus.Rs2_id          = 5'd0;
        bus.RfData1_in      = 32'd0;
        bus.RfData2_in      = 32'd0;
    endtask

    task automatic issue(input logic m2r, input logic rw, input logic mw,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] sd, input logic nos);
        bus.Ctl_MemtoReg_in = m2r;
        bus.Ctl_RegWrite_in = rw;
        bus.Ctl_MemWrite_in = mw;
        bus.Rd_in           = rd;
        bus.ALUresult_in    = alu;
        bus.MemWriteData_in = sd;
        bus.NOS_in          = nos;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.Ctl_MemtoReg_in = 1'($urandom);
            bus.Ctl_RegWrite_in = 1'($urandom);
            bus.Ctl_MemWrite_in = 1'($urandom);
            bus.Rd_in           = 5'($urandom);
            bus.ALUresult_in    = $urandom;
            bus.MemWriteData_in = $urandom;
            bus.NOS_in          = 1'($urandom);
            tick();
        end
        bubble();
        #1;
        total_cnt++;
        if (bus.Rf_we_out !== 1'b0)
            $display("FAIL reset_rf_we got %0b want 0", bus.Rf_we_out);
        else pass_cnt++;
        total_cnt++;
        if (bus.WriteData_out !== 32'd0)
            $display("FAIL reset_writedata got %h want 0", bus.WriteData_out);
        else pass_cnt++;
        total_cnt++;
        if (bus.EXE_forwarding_out !== 2'b00)
            $display("FAIL reset_fwd got %b want 00", bus.EXE_forwarding_out);
        else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu_path();
        issue(1'b0, 1'b1, 1'b0, 5'd5, 32'h1234, 32'd0, 1'b0);
        tick();
        bubble();
        #1;
        total_cnt++;
        if (bus.WriteData_out !== 32'h1234)
            $display("FAIL alu_mem_result got %h want 00001234", bus.WriteData_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.Rf_we_out !== 1'b1 || bus.Rf_waddr_out !== 5'd5 || bus.Rf_wdata_out !== 32'h1234)
            $display("FAIL alu_wb got we=%0b a=%0d d=%h want we=1 a=5 d=00001234",
                     bus.Rf_we_out, bus.Rf_waddr_out, bus.Rf_wdata_out);
        else pass_cnt++;
        total_cnt++;
        if (bus.WriteData_out !== 32'd0)
            $display("FAIL alu_bubble_result got %h want 0", bus.WriteData_out);
        else pass_cnt++;
    endtask

    task automatic test_store_load();
        issue(1'b0, 1'b0, 1'b1, 5'd0, 32'h40, 32'hDEADBEEF, 1'b0);
        tick();
        issue(1'b1, 1'b1, 1'b0, 5'd6, 32'h43, 32'd0, 1'b0);
        tick();
        issue(1'b1, 1'b1, 1'b0, 5'd9, 32'h440, 32'd0, 1'b0);
        #1;
        total_cnt++;
        if (bus.WriteData_out !== 32'hDEADBEEF)
            $display("FAIL store_then_load got %h want deadbeef", bus.WriteData_out);
        else pass_cnt++;
        tick();
        bubble();
        #1;
        total_cnt++;
        if (bus.WriteData_out !== 32'hDEADBEEF)
            $display("FAIL alias_load got %h want deadbeef", bus.WriteData_out);
        else pass_cnt++;
        total_cnt++;
        if (bus.Rf_we_out !== 1'b1 || bus.Rf_waddr_out !== 5'd6 || bus.Rf_wdata_out !== 32'hDEADBEEF)
            $display("FAIL load_wb got we=%0b a=%0d d=%h want we=1 a=6 d=deadbeef",
                     bus.Rf_we_out, bus.Rf_waddr_out, bus.Rf_wdata_out);
        else pass_cnt++;
        tick();
        // Squashed store must not modify memory.
        issue(1'b0, 1'b0, 1'b1, 5'd0, 32'h80, 32'h22, 1'b0);
        tick();
        issue(1'b0, 1'b0, 1'b1, 5'd0, 32'h80, 32'h33, 1'b1);
        tick();
        issue(1'b1, 1'b1, 1'b0, 5'd4, 32'h82, 32'd0, 1'b0);
        tick();
        bubble();
        #1;
        total_cnt++;
        if (bus.WriteData_out !== 32'h22)
            $display("FAIL nos_store_squash got %h want 00000022", bus.WriteData_out);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_store();
        issue(1'b0, 1'b0, 1'b1, 5'd0, 32'h100, 32'h77, 1'b0);
        tick();
        issue(1'b0, 1'b0, 1'b1, 5'd0, 32'h100, 32'h88, 1'b0);
        tick();
        bubble();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if (bus.Rf_we_out !== 1'b0 || bus.WriteData_out !== 32'd0)
            $display("FAIL midreset_clear got we=%0b wd=%h want we=0 wd=0",
                     bus.Rf_we_out, bus.WriteData_out);
        else pass_cnt++;
        issue(1'b1, 1'b1, 1'b0, 5'd2, 32'h100, 32'd0, 1'b0);
        tick();
        bubble();
        #1;
        total_cnt++;
        if (bus.WriteData_out !== 32'h77)
            $display("FAIL midreset_store_dropped got %h want 00000077", bus.WriteData_out);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_forwarding();
        logic [1:0] exp [5];
        logic [4:0] rd_v [5];
        logic [4:0] rs2_v [5];
        logic       nos_v [5];
        logic       rw_v [5];
        rd_v  = '{5'd3, 5'd3, 5'd0, 5'd3, 5'd3};
        rs2_v = '{5'd3, 5'd3, 5'd0, 5'd4, 5'd3};
        nos_v = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        rw_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp   = '{2'b11, 2'b00, 2'b00, 2'b01, 2'b00};
        for (int i = 0; i < 5; i++) begin
            bubble();
            bus.Ctl_RegWrite_in = rw_v[i];
            bus.Rd_in           = rd_v[i];
            bus.NOS_in          = nos_v[i];
            bus.Rs1_id          = (i == 2) ? 5'd0 : 5'd3;
            bus.Rs2_id          = rs2_v[i];
            #1;
            total_cnt++;
            if (bus.EXE_forwarding_out !== exp[i])
                $display("FAIL fwd_case%0d got %b want %b", i, bus.EXE_forwarding_out, exp[i]);
            else pass_cnt++;
        end
        bubble();
        tick();
    endtask

    task automatic test_x0();
        issue(1'b0, 1'b1, 1'b0, 5'd0, 32'h55, 32'd0, 1'b0);
        tick();
        bubble();
        tick();
        total_cnt++;
        if (bus.Rf_we_out !== 1'b0)
            $display("FAIL x0_no_write got %0b want 0", bus.Rf_we_out);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        logic [31:0] exp1;
        issue(1'b0, 1'b1, 1'b0, 5'd7, 32'hA5, 32'd0, 1'b0);
        tick();
        bubble();
        tick();
        bus.Rs1_id     = 5'd7;
        bus.RfData1_in = 32'd0;
        bus.Rs2_id     = 5'd8;
        bus.RfData2_in = 32'h99;
        #1;
`ifdef STAGE3_WB_BYPASS_EN
        exp1 = 32'hA5;
`else
        exp1 = 32'h0;
`endif
        total_cnt++;
        if (bus.RegData1_out !== exp1)
            $display("FAIL bypass_rs1 got %h want %h", bus.RegData1_out, exp1);
        else pass_cnt++;
        total_cnt++;
        if (bus.RegData2_out !== 32'h99)
            $display("FAIL bypass_rs2_raw got %h want 00000099", bus.RegData2_out);
        else pass_cnt++;
        bubble();
        tick();
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 1'b1, 1'b0, 5'd10, 32'h111, 32'd0, 1'b0);
        tick();
        issue(1'b0, 1'b1, 1'b0, 5'd11, 32'h222, 32'd0, 1'b0);
        tick();
        bubble();
        #1;
        total_cnt++;
        if (bus.WriteData_out !== 32'h222 || bus.Rf_waddr_out !== 5'd10 || bus.Rf_wdata_out !== 32'h111)
            $display("FAIL b2b_stage1 got wd=%h a=%0d d=%h want wd=00000222 a=10 d=00000111",
                     bus.WriteData_out, bus.Rf_waddr_out, bus.Rf_wdata_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.Rf_we_out !== 1'b1 || bus.Rf_waddr_out !== 5'd11 || bus.Rf_wdata_out !== 32'h222)
            $display("FAIL b2b_stage2 got we=%0b a=%0d d=%h want we=1 a=11 d=00000222",
                     bus.Rf_we_out, bus.Rf_waddr_out, bus.Rf_wdata_out);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        bubble();
        test_reset();
        test_alu_path();
        test_store_load();
        test_reset_mid_store();
        test_forwarding();
        test_x0();
        test_bypass();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/stage3_mem_wb.md
# stage3_mem_wb

Memory/writeback stage of the 5-stage RISC-V core; it is the far end of the EX stage's forwarding interface. Registers the EX outputs, performs word-wide data-memory access, and drives the MEM-stage result (`WriteData_out`) back to EX as the forwarding source. Computes the 2-bit forwarding select captured by the ID/EX register, owns the WB register that writes the register file, and optionally bypasses WB data into ID register reads.

## Interface
Parameters:
- `ADDR_W`, 8: data-memory word-address width (2^ADDR_W words of 32 bits).

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `Ctl_MemtoReg_in`  in  1  EX->MEM: instruction is a load.
- `Ctl_RegWrite_in`  in  1  EX->MEM: instruction writes Rd.
- `Ctl_MemWrite_in`  in  1  EX->MEM: instruction is a store.
- `Rd_in`  in  5  EX->MEM destination register.
- `ALUresult_in`  in  32  EX result / byte address.
- `MemWriteData_in`  in  32  store data (already forwarded by EX).
- `NOS_in`  in  1  squash of the instruction currently in EX.
- `Rs1_id`, `Rs2_id`  in  5 each  source registers of the instruction in ID.
- `RfData1_in`, `RfData2_in`  in  32 each  raw register-file read data for ID.
- `WriteData_out`  out  32  MEM-stage result to EX `WriteData_in`.
- `EXE_forwarding_out`  out  2  forwarding select for the ID instruction ([0]=Rs1, [1]=Rs2).
- `RegData1_out`, `RegData2_out`  out  32 each  ID register operands (bypassed or raw).
- `Rf_we_out`  out  1  register-file write enable.
- `Rf_waddr_out`  out  5  register-file write address.
- `Rf_wdata_out`  out  32  register-file write data.

## Operation
- MEM register: each posedge captures `Ctl_*_in`, `Rd_in`, `ALUresult_in`, `MemWriteData_in`. If `NOS_in`, captured RegWrite, MemtoReg and MemWrite are forced to 0.
- Data memory: word index = `ALUresult_mem[ADDR_W+1:2]`; bits [1:0] ignored; no alignment fault. Address bits above ADDR_W+1 are ignored, so addresses wrap modulo 2^ADDR_W words.
- Read is combinational. Write is synchronous at the posedge ending the store's MEM cycle.
- `WriteData_out` = MemtoReg_mem ? mem[index] : ALUresult_mem; combinational.
- Store followed by a load to the same word in the next cycle returns the new data, because the write completes before the load reaches MEM.
- WB register: each posedge captures RegWrite_mem, Rd_mem, `WriteData_out`. Drives `Rf_we_out`, `Rf_waddr_out`, `Rf_wdata_out`.
- `Rf_we_out` is forced to 0 when Rd_wb = 0, so x0 is never written.
- `EXE_forwarding_out[k]` = `Ctl_RegWrite_in` & ~`NOS_in` & (`Rd_in` != 0) & (`Rd_in` == Rs(k+1)_id). This is combinational and is latched by the ID/EX register, so it is valid when the ID instruction is in EX and the producer is in MEM.
- Both forwarding bits may be set simultaneously when Rs1_id = Rs2_id = `Rd_in`.

## Timing
- Reset values: MEM and WB control bits 0, Rd 0, data registers 0. `WriteData_out` = 0 while MemtoReg_mem = 0; `Rf_we_out` = 0. Memory contents are not reset.
- Latency: ALU result to `WriteData_out` is 1 cycle; to `Rf_wdata_out` is 2 cycles.
- Reset asserted mid-operation: an in-flight store in MEM at that edge is not written; pipeline registers clear on that edge.
- No handshake; no stall is required for load-use, since the read is same-cycle.

## Configuration
- `STAGE3_WB_BYPASS_EN` defined: `RegDataN_out` = `Rf_wdata_out` when `Rf_we_out` & (`Rf_waddr_out` == RsN_id); otherwise `RfDataN_in`. This covers the distance-3 hazard.
- `STAGE3_WB_BYPASS_EN` undefined: `RegDataN_out` = `RfDataN_in` unconditionally. The register file must then be write-first.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs -> `Rf_we_out` = 0, `WriteData_out` = 0, `EXE_forwarding_out` = 2'b00.
- ALU path: RegWrite, Rd = 5, ALUresult = 0x1234 -> `WriteData_out` = 0x1234 next cycle; `Rf_we_out` = 1, addr 5, data 0x1234 one cycle later.
- Store/load: store 0xDEADBEEF at 0x40, then load 0x43 -> load's `WriteData_out` = 0xDEADBEEF. Address 0x40 + 4·2^ADDR_W aliases the same word.
- Forwarding: `Rd_in` = 3 with RegWrite and Rs1_id = Rs2_id = 3 -> 2'b11. Same with `NOS_in` = 1 -> 2'b00. With `Rd_in` = 0 -> 2'b00.
- x0: RegWrite with Rd = 0 -> `Rf_we_out` = 0 in WB.
- Bypass: `Rf_waddr_out` = 7, `Rf_wdata_out` = 0xA5, Rs1_id = 7, `RfData1_in` = 0 -> `RegData1_out` = 0xA5 with `STAGE3_WB_BYPASS_EN` defined, 0 without it.
